serial_subtractor: RTL and testbench

Bit-serial unsigned/two's-complement subtractor computing Diff = A − B one bit per clock, LSB first, through a single full-subtractor cell. It is the inverse-operation counterpart of the team's full-adder datapath cell. It serves area-constrained datapaths where WIDTH-cycle latency is acceptable. Operands are captured on a start handshake, and results are held stable until the next accepted start.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Operand/result width used when the instantiating level does not override it.
  localparam int unsigned DefaultWidth = 8;

  // Controller states; encoding is fixed so state dumps stay readable across revisions.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
);

  logic             start;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             busy;
  logic             done;
  logic [Width-1:0] diff;
  logic             bout;
  logic             ovf;

  // Requester side: issues operands, observes status and results.
  modport master (
    output start, a, b,
    input  busy, done, diff, bout, ovf
  );

  // Subtractor side.
  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic a_xor_b;

  assign a_xor_b = a_i ^ b_i;
  assign d_o     = a_xor_b ^ bin_i;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout_o  = (~a_i & b_i) | (~a_xor_b & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor cell, Width+1 cycle latency.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  state_e           state_q, state_d;
  logic [Width-1:0] a_sr_q, a_sr_d;
  logic [Width-1:0] b_sr_q, b_sr_d;
  logic [Width-1:0] d_sr_q, d_sr_d;
  logic [Width-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  // Next-state for controller, datapath shift registers and result registers.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          d_sr_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        a_sr_d   = {1'b0, a_sr_q[Width-1:1]};
        b_sr_d   = {1'b0, b_sr_q[Width-1:1]};
        d_sr_d   = {cell_d, d_sr_q[Width-1:1]};
        borrow_d = cell_bout;
        if (cnt_q == LastCnt) begin
          // MSB step: publish results so they appear together with done.
          diff_d  = {cell_d, d_sr_q[Width-1:1]};
          bout_d  = cell_bout;
          ovf_d   = borrow_q ^ cell_bout;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        // Start is deliberately not sampled here; it is only honoured in idle.
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state, including registered outputs, with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at Width 8 and 13.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  serial_subtractor_if #(.Width(8))  if8 ();
  serial_subtractor_if #(.Width(13)) if13 ();

  serial_subtractor #(.Width(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  serial_subtractor #(.Width(13)) u_dut13 (
    .clk (clk),
    .rst (rst),
    .bus (if13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: modular difference, unsigned borrow, signed overflow.
  function automatic void model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic bo, output logic ov);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    d    = (a - b) & mask;
    bo   = (a & mask) < (b & mask);
    ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
  endfunction

  // One Width-8 operation from idle, with latency/busy checks; operands scrambled after accept.
  // poke pulses start in RUN and in DONE; both must be ignored.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb, input logic eo, input bit poke);
    int cyc;
    int busy_n;
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a     = ~a;
    if8.b     = a ^ b ^ 8'h5A;
    cyc       = 1;
    busy_n    = if8.busy ? 1 : 0;
    chk({tag, "/busy1"}, 32'(if8.busy), 32'd1);
    while (!if8.done && cyc < 40) begin
      if8.start = poke && (cyc == 3);
      @(posedge clk); #1;
      cyc++;
      if (if8.busy) busy_n++;
    end
    chk({tag, "/done_cyc"}, 32'(cyc), 32'd9);
    chk({tag, "/busy_cnt"}, 32'(busy_n), 32'd9);
    chk({tag, "/diff"}, 32'(if8.diff), 32'(ed));
    chk({tag, "/bout"}, 32'(if8.bout), 32'(eb));
    chk({tag, "/ovf"}, 32'(if8.ovf), 32'(eo));
    if8.start = poke;
    @(posedge clk); #1;
    if8.start = 1'b0;
    chk({tag, "/done_pulse"}, 32'(if8.done), 32'd0);
    chk({tag, "/busy_clr"}, 32'(if8.busy), 32'd0);
    chk({tag, "/diff_hold"}, 32'(if8.diff), 32'(ed));
  endtask

  task automatic run13(input logic [12:0] a, input logic [12:0] b);
    logic [31:0] ed;
    logic        eb;
    logic        eo;
    int          cyc;
    model(13, {19'd0, a}, {19'd0, b}, ed, eb, eo);
    if13.start = 1'b1;
    if13.a     = a;
    if13.b     = b;
    @(posedge clk); #1;
    if13.start = 1'b0;
    cyc        = 1;
    while (!if13.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("r13/done_cyc", 32'(cyc), 32'd14);
    chk("r13/diff", {19'd0, if13.diff}, ed);
    chk("r13/bout", 32'(if13.bout), 32'(eb));
    chk("r13/ovf", 32'(if13.ovf), 32'(eo));
    @(posedge clk); #1;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (if8.done) n++;
    end
  endtask

  initial begin
    logic [31:0] ed;
    logic        eb;
    logic        eo;
    logic [7:0]  ra;
    logic [7:0]  rb;
    int          nd;
    int          q[$];

    n_cmp      = 0;
    n_mis      = 0;
    rst        = 1'b0;
    if8.start  = 1'b0;
    if8.a      = '0;
    if8.b      = '0;
    if13.start = 1'b0;
    if13.a     = '0;
    if13.b     = '0;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/busy", 32'(if8.busy), 32'd0);
    chk("rst/done", 32'(if8.done), 32'd0);
    chk("rst/diff", 32'(if8.diff), 32'd0);
    chk("rst/bout", 32'(if8.bout), 32'd0);
    chk("rst/ovf", 32'(if8.ovf), 32'd0);
    chk("rst/diff13", 32'(if13.diff), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run8("35-12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0);
    run8("12-35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 1'b0);
    run8("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run8("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    run8("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Start held high: one result every Width+2 cycles.
    if8.a     = 8'h00;
    if8.b     = 8'h00;
    if8.start = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (if8.done) q.push_back(i);
    end
    if8.start = 1'b0;
    chk("b2b/count", 32'(q.size()), 32'd3);
    if (q.size() >= 3) begin
      chk("b2b/gap1", 32'(q[1] - q[0]), 32'd10);
      chk("b2b/gap2", 32'(q[2] - q[1]), 32'd10);
    end
    chk("b2b/diff", 32'(if8.diff), 32'd0);
    repeat (12) @(posedge clk);
    #1;

    // Start pulses in RUN and DONE must not launch another operation.
    run8("poke", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b1);
    count_dones(20, nd);
    chk("poke/extra_done", 32'(nd), 32'd0);
    chk("poke/idle", 32'(if8.busy), 32'd0);

    // Leave non-zero results, then reset in the middle of the next operation.
    run8("7F-FF#2", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    if8.start = 1'b1;
    if8.a     = 8'h35;
    if8.b     = 8'h12;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst/busy", 32'(if8.busy), 32'd0);
    chk("mid_rst/done", 32'(if8.done), 32'd0);
    chk("mid_rst/diff", 32'(if8.diff), 32'd0);
    chk("mid_rst/bout", 32'(if8.bout), 32'd0);
    chk("mid_rst/ovf", 32'(if8.ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_dones(15, nd);
    chk("mid_rst/no_done", 32'(nd), 32'd0);
    run8("A0-0A", 8'hA0, 8'h0A, 8'h96, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(8, {24'd0, ra}, {24'd0, rb}, ed, eb, eo);
      run8("r8", ra, rb, ed[7:0], eb, eo, 1'b0);
    end

    for (int i = 0; i < 1000; i++) begin
      run13(13'($urandom), 13'($urandom));
    end
    run13(13'h1000, 13'h0001);
    run13(13'h0FFF, 13'h1FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
